// File: rtl/ticker_sched.sv
// Sequencer for a shift-register character ticker: loads a short message, then rotates it.
// Optional auto-stop after ROTATIONS revolutions is enabled by defining TICKER_AUTOSTOP_EN.
module ticker_sched #(
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned ROTATIONS = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_pause,
    input  logic       i_msg_sel,
    output logic       o_shift_en,
    output logic [6:0] o_char,
    output logic       o_lock,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_state
);

    localparam int unsigned TICKS = ROTATIONS * DEPTH;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TCK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(TICKS - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DEPTH - 1);

    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROTATE = 2'd2
    } state_t;

    state_t           r_state, w_state_d;
    logic [2:0]       r_idx, w_idx_d;
    logic [DIV_W-1:0] r_div, w_div_d;
    logic [TCK_W-1:0] r_tick, w_tick_d;
    logic             r_msg_sel, w_msg_sel_d;
    logic             r_done, w_done_d;

    logic             w_active;
    logic             w_strobe;
    logic [DIV_W-1:0] w_div_next;
    logic [6:0]       w_entry;

    assign w_active   = (r_state == S_LOAD) || (r_state == S_ROTATE);
    assign w_strobe   = w_active && !i_pause && (r_div == DIV_LAST);
    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

    // Entries past the message length are blanks; entries past DEPTH are never reached.
    always_comb begin
        w_entry = SEG_BLANK;
        if (!r_msg_sel) begin
            case (r_idx)
                3'd0:    w_entry = SEG_H;
                3'd1:    w_entry = SEG_E;
                3'd2:    w_entry = SEG_L;
                3'd3:    w_entry = SEG_L;
                3'd4:    w_entry = SEG_O;
                default: w_entry = SEG_BLANK;
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_entry = SEG_C;
                3'd1:    w_entry = SEG_A;
                3'd2:    w_entry = SEG_F;
                3'd3:    w_entry = SEG_E;
                default: w_entry = SEG_BLANK;
            endcase
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_div_d     = r_div;
        w_tick_d    = r_tick;
        w_msg_sel_d = r_msg_sel;
        w_done_d    = 1'b0;

        if (i_stop) begin
            w_state_d = S_IDLE;
            w_idx_d   = '0;
            w_div_d   = '0;
            w_tick_d  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_d   = S_LOAD;
                        w_msg_sel_d = i_msg_sel;
                        w_idx_d     = '0;
                        w_div_d     = '0;
                        w_tick_d    = '0;
                    end
                end
                S_LOAD: begin
                    if (!i_pause) begin
                        w_div_d = w_div_next;
                    end
                    if (w_strobe) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_d = S_ROTATE;
                            w_idx_d   = '0;
                        end else begin
                            w_idx_d = r_idx + 3'd1;
                        end
                    end
                end
                S_ROTATE: begin
                    if (!i_pause) begin
                        w_div_d = w_div_next;
                    end
                    if (w_strobe) begin
`ifdef TICKER_AUTOSTOP_EN
                        if (r_tick == TCK_LAST) begin
                            w_state_d = S_IDLE;
                            w_tick_d  = '0;
                            w_done_d  = 1'b1;
                        end else begin
                            w_tick_d = r_tick + TCK_W'(1);
                        end
`else
                        w_tick_d = (r_tick == TCK_LAST) ? '0 : r_tick + TCK_W'(1);
`endif
                    end
                end
                default: begin
                    // Illegal encoding recovers to IDLE.
                    w_state_d = S_IDLE;
                    w_idx_d   = '0;
                    w_div_d   = '0;
                    w_tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_div     <= '0;
            r_tick    <= '0;
            r_msg_sel <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_div     <= w_div_d;
            r_tick    <= w_tick_d;
            r_msg_sel <= w_msg_sel_d;
            r_done    <= w_done_d;
        end
    end

    assign o_shift_en = w_strobe;
    assign o_char     = (r_state == S_LOAD) ? w_entry : SEG_BLANK;
    assign o_lock     = (r_state == S_ROTATE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_state    = r_state;

endmodule

// File: tb/tb_ticker_sched.sv
// Self-checking bench for ticker_sched: scoreboard of expected strobes plus a ticker model.
// Expectations for auto-stop follow whether TICKER_AUTOSTOP_EN is defined.
module tb_ticker_sched;

    localparam logic [6:0] H = 7'b0001001;
    localparam logic [6:0] E = 7'b0000110;
    localparam logic [6:0] L = 7'b1000111;
    localparam logic [6:0] O = 7'b1000000;
    localparam logic [6:0] C = 7'b1000110;
    localparam logic [6:0] A = 7'b0001000;
    localparam logic [6:0] F = 7'b0001110;
    localparam logic [6:0] B = 7'b1111111;

    typedef struct {
        logic [6:0] ch;
        logic       lk;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, stop, pause, msg_sel;
    logic       f_shift_en, f_lock, f_busy, f_done;
    logic [6:0] f_char;
    logic [1:0] f_state;
    logic       s_shift_en, s_lock, s_busy, s_done;
    logic [6:0] s_char;
    logic [1:0] s_state;

    int total = 0;
    int bad   = 0;
    int f_done_cnt = 0;
    exp_t q[$];
    logic [6:0] tk [5];

    always #5 clk = ~clk;

    always @(negedge clk) if (f_done === 1'b1) f_done_cnt++;

    ticker_sched #(.DEPTH(5), .TICK_DIV(1), .ROTATIONS(2)) u_fast (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_pause(pause),
        .i_msg_sel(msg_sel), .o_shift_en(f_shift_en), .o_char(f_char), .o_lock(f_lock),
        .o_busy(f_busy), .o_done(f_done), .o_state(f_state)
    );

    ticker_sched #(.DEPTH(5), .TICK_DIV(4), .ROTATIONS(2)) u_slow (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_pause(pause),
        .i_msg_sel(msg_sel), .o_shift_en(s_shift_en), .o_char(s_char), .o_lock(s_lock),
        .o_busy(s_busy), .o_done(s_done), .o_state(s_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; pause = 1'b0; msg_sel = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        f_done_cnt = 0;
        q.delete();
        for (int i = 0; i < 5; i++) tk[i] = 7'h00;
    endtask

    task automatic push(input logic [6:0] ch, input logic lk, input int t);
        exp_t e;
        e.ch = ch; e.lk = lk; e.t = t;
        q.push_back(e);
    endtask

    task automatic tk_shift(input logic [6:0] ch, input logic lk);
        logic [6:0] last;
        last = tk[4];
        for (int i = 4; i > 0; i--) tk[i] = tk[i-1];
        tk[0] = lk ? last : ch;
    endtask

    // Drain the scoreboard against the TICK_DIV=1 instance; returns cycles consumed.
    task automatic run_fast(input string name, input int budget, output int cycles);
        exp_t e;
        cycles = 0;
        while (q.size() > 0 && cycles < budget) begin
            if (f_shift_en === 1'b1) begin
                e = q.pop_front();
                total++;
                if (f_char !== e.ch || f_lock !== e.lk) begin
                    bad++;
                    $display("FAIL %s strobe char/lock got %h/%b want %h/%b",
                             name, f_char, f_lock, e.ch, e.lk);
                end
                tk_shift(f_char, f_lock);
            end
            step();
            cycles++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout got %0d pending strobes want 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1; stop = 1'b0; pause = 1'b0; msg_sel = 1'b0;
        step(); step();
        total++;
        if ({f_state, f_shift_en, f_lock, f_char, f_busy, f_done} !== {2'd0, 1'b0, 1'b0, B, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_fast got st=%0d se=%b lk=%b ch=%h bz=%b dn=%b want 0/0/0/7f/0/0",
                     f_state, f_shift_en, f_lock, f_char, f_busy, f_done);
        end
        total++;
        if ({s_state, s_shift_en, s_lock, s_char, s_busy, s_done} !== {2'd0, 1'b0, 1'b0, B, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_slow got st=%0d se=%b lk=%b ch=%h bz=%b dn=%b want 0/0/0/7f/0/0",
                     s_state, s_shift_en, s_lock, s_char, s_busy, s_done);
        end
        start = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_hello();
        int cyc;
        do_reset();
        msg_sel = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        push(H, 0, 0); push(E, 0, 0); push(L, 0, 0); push(L, 0, 0); push(O, 0, 0);
        run_fast("hello_load", 20, cyc);
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("FAIL hello_consecutive got %0d cycles want 5", cyc);
        end
        total++;
        if (f_lock !== 1'b1 || f_state !== 2'd2) begin
            bad++;
            $display("FAIL hello_rotate_entry got lk=%b st=%0d want 1/2", f_lock, f_state);
        end
        total++;
        if ({tk[4], tk[3], tk[2], tk[1], tk[0]} !== {H, E, L, L, O}) begin
            bad++;
            $display("FAIL hello_ticker got %h %h %h %h %h want HELLO codes",
                     tk[4], tk[3], tk[2], tk[1], tk[0]);
        end
        for (int i = 0; i < 10; i++) push(B, 1, 0);
        run_fast("hello_rotate", 30, cyc);
`ifdef TICKER_AUTOSTOP_EN
        total++;
        if (f_state !== 2'd0 || f_done !== 1'b1) begin
            bad++;
            $display("FAIL hello_autostop got st=%0d dn=%b want 0/1", f_state, f_done);
        end
        step();
        total++;
        if (f_done !== 1'b0 || f_done_cnt !== 1) begin
            bad++;
            $display("FAIL hello_done_width got dn=%b cnt=%0d want 0/1", f_done, f_done_cnt);
        end
`else
        for (int i = 0; i < 90; i++) push(B, 1, 0);
        run_fast("hello_rotate100", 200, cyc);
        total++;
        if (f_state !== 2'd2 || f_done_cnt !== 0) begin
            bad++;
            $display("FAIL hello_no_autostop got st=%0d dones=%0d want 2/0", f_state, f_done_cnt);
        end
        stop = 1'b1; step(); stop = 1'b0;
`endif
        total++;
        if ({tk[4], tk[3], tk[2], tk[1], tk[0]} !== {H, E, L, L, O}) begin
            bad++;
            $display("FAIL hello_ticker_after got %h %h %h %h %h want HELLO codes",
                     tk[4], tk[3], tk[2], tk[1], tk[0]);
        end
    endtask

    task automatic test_cafe();
        int cyc;
        do_reset();
        msg_sel = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        msg_sel = 1'b0;
        push(C, 0, 0); push(A, 0, 0); push(F, 0, 0); push(E, 0, 0); push(B, 0, 0);
        run_fast("cafe_load", 20, cyc);
        for (int i = 0; i < 10; i++) push(B, 1, 0);
        run_fast("cafe_rotate", 30, cyc);
        total++;
        if ({tk[4], tk[3], tk[2], tk[1], tk[0]} !== {C, A, F, E, B}) begin
            bad++;
            $display("FAIL cafe_ticker got %h %h %h %h %h want CAFE_ codes",
                     tk[4], tk[3], tk[2], tk[1], tk[0]);
        end
`ifdef TICKER_AUTOSTOP_EN
        total++;
        if (f_state !== 2'd0 || f_done !== 1'b1) begin
            bad++;
            $display("FAIL cafe_autostop got st=%0d dn=%b want 0/1", f_state, f_done);
        end
`else
        total++;
        if (f_state !== 2'd2 || f_done_cnt !== 0) begin
            bad++;
            $display("FAIL cafe_rotating got st=%0d dones=%0d want 2/0", f_state, f_done_cnt);
        end
`endif
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_div4_pause();
        exp_t e;
        do_reset();
        msg_sel = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        // Nominal strobes at 3,7,11,...; the 6-cycle pause shifts all after 7 by 6.
        push(H, 0, 3); push(E, 0, 7); push(L, 0, 17); push(L, 0, 21); push(O, 0, 25);
        push(B, 1, 29); push(B, 1, 33);
        for (int c = 0; c < 45 && q.size() > 0; c++) begin
            pause = (c >= 9 && c <= 14);
            #1;
            if (c == 12) begin
                total++;
                if (s_shift_en !== 1'b0 || s_char !== L || s_lock !== 1'b0 || s_state !== 2'd1) begin
                    bad++;
                    $display("FAIL div4_paused got se=%b ch=%h lk=%b st=%0d want 0/47/0/1",
                             s_shift_en, s_char, s_lock, s_state);
                end
            end
            if (s_shift_en === 1'b1) begin
                e = q.pop_front();
                total++;
                if (c !== e.t || s_char !== e.ch || s_lock !== e.lk) begin
                    bad++;
                    $display("FAIL div4_strobe got t=%0d ch=%h lk=%b want t=%0d ch=%h lk=%b",
                             c, s_char, s_lock, e.t, e.ch, e.lk);
                end
            end
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL div4_timeout got %0d pending want 0", q.size());
        end
        q.delete();
        stop = 1'b1; step(); stop = 1'b0;
        total++;
        if (s_state !== 2'd0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL div4_stop got st=%0d bz=%b want 0/0", s_state, s_busy);
        end
    endtask

    task automatic test_start_stop();
        int cyc;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        push(H, 0, 0); push(E, 0, 0); push(L, 0, 0); push(L, 0, 0); push(O, 0, 0);
        push(B, 1, 0); push(B, 1, 0);
        run_fast("ss_prefix", 20, cyc);
        start = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (f_state !== 2'd0 || f_busy !== 1'b0 || f_done !== 1'b0) begin
            bad++;
            $display("FAIL ss_stop_wins got st=%0d bz=%b dn=%b want 0/0/0", f_state, f_busy, f_done);
        end
        step();
        start = 1'b0;
        total++;
        if (f_state !== 2'd1 || f_busy !== 1'b1 || f_char !== H || f_done_cnt !== 0) begin
            bad++;
            $display("FAIL ss_restart got st=%0d bz=%b ch=%h dones=%0d want 1/1/09/0",
                     f_state, f_busy, f_char, f_done_cnt);
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        push(H, 0, 0); push(E, 0, 0);
        run_fast("rml_prefix", 10, cyc);
        total++;
        if (f_char !== L || f_state !== 2'd1) begin
            bad++;
            $display("FAIL rml_idx2 got ch=%h st=%0d want 47/1", f_char, f_state);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (f_state !== 2'd0 || f_shift_en !== 1'b0 || f_char !== B || f_lock !== 1'b0 ||
            f_busy !== 1'b0 || f_done !== 1'b0) begin
            bad++;
            $display("FAIL rml_async got st=%0d se=%b ch=%h lk=%b bz=%b dn=%b want 0/0/7f/0/0/0",
                     f_state, f_shift_en, f_char, f_lock, f_busy, f_done);
        end
        step();
        reset = 1'b0;
        step();
        total++;
        if (f_state !== 2'd0 || f_done_cnt !== 0) begin
            bad++;
            $display("FAIL rml_idle_after got st=%0d dones=%0d want 0/0", f_state, f_done_cnt);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        push(H, 0, 0); push(E, 0, 0); push(L, 0, 0); push(L, 0, 0); push(O, 0, 0);
        run_fast("rml_reload", 20, cyc);
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; msg_sel = 1'b0;
        test_reset();
        test_hello();
        test_cafe();
        test_div4_pause();
        test_start_stop();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ticker_sched.md
TICKER_SCHED -- requirements
Module: ticker_sched

Interface
REQ-001 Parameter DEPTH, default 5: shift-ticker stage count, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 4: clocks per shift strobe, legal range >=1.
REQ-003 Parameter ROTATIONS, default 2: full revolutions before auto-stop, legal range >=1.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begins a load-then-rotate sequence; acted on only in IDLE.
REQ-007 stop  input  1  aborts any sequence and returns to IDLE.
REQ-008 pause  input  1  level; freezes the sequence while high.
REQ-009 msg_sel  input  1  selects message: 0 = H,E,L,L,O; 1 = C,A,F,E.
REQ-010 shift_en  output  1  one-cycle strobe; the shift ticker advances on it.
REQ-011 char  output  7  active-low segment code fed to the ticker input.
REQ-012 lock  output  1  1 = ticker recirculates its last stage; 0 = ticker loads char.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle pulse on auto-stop completion.
REQ-015 state  output  2  FSM state: IDLE=0, LOAD=1, ROTATE=2.

Function
REQ-016 Segment codes: H=0001001, E=0000110, L=1000111, O=1000000, C=1000110, A=0001000, F=0001110, blank=1111111.
REQ-017 Load sequence is DEPTH entries long: message characters first, then blanks. Characters beyond DEPTH are dropped.
REQ-018 Divider div counts 0..TICK_DIV-1, then wraps. It advances only in LOAD or ROTATE while pause=0, and clears to 0 on start acceptance.
REQ-019 shift_en = (state != IDLE) & ~pause & (div == TICK_DIV-1). It is combinational and never high in IDLE.
REQ-020 IDLE: lock=0, char=blank. start=1 with stop=0 selects LOAD next edge, latches msg_sel, and clears idx and div.
REQ-021 Latency: the first strobed edge is the TICK_DIV-th posedge after the accepting edge.
REQ-022 LOAD: lock=0, char=entry[idx].
REQ-023 In LOAD, each strobed edge increments idx. At idx=DEPTH-1 the strobed edge selects ROTATE and clears idx.
REQ-024 ROTATE: lock=1, char=blank, and shift_en continues at the divider rate.
REQ-025 In ROTATE, a tick counter counts strobes, range 0..ROTATIONS*DEPTH-1.
REQ-026 start while busy SHALL be ignored. msg_sel SHALL be sampled only on acceptance.
REQ-027 stop=1 in any state selects IDLE on the next edge and clears idx, div and the tick counter. stop overrides start and pause.
REQ-028 pause=1 holds state, idx, div and the tick counter, and forces shift_en=0. Outputs char and lock keep their state-defined values.
REQ-029 busy = (state != IDLE). An encoding of 3 SHALL fall back to IDLE on the next edge.

Reset
REQ-030 reset=1 asynchronously forces state=IDLE and idx=div=tick counter=0, and clears done and the latched msg_sel.
REQ-031 While reset=1, outputs SHALL be shift_en=0, lock=0, char=blank, busy=0, done=0.
REQ-032 Reset asserted mid-LOAD or mid-ROTATE abandons the sequence. No done pulse is issued.

Configuration
REQ-033 Macro TICKER_AUTOSTOP_EN defined: in ROTATE, the strobed edge with tick counter = ROTATIONS*DEPTH-1 selects IDLE and sets done=1 for exactly the following cycle.
REQ-034 TICKER_AUTOSTOP_EN undefined: ROTATE persists until stop or reset. The tick counter wraps, done is tied to 0, and the port remains present.

Verification
REQ-035 TICK_DIV=1, msg_sel=0, start pulse:
- shift_en is high for 5 consecutive cycles with char = H,E,L,L,O and lock=0.
- lock=1 follows.
- An attached 5-stage ticker then holds H,E,L,L,O in order.
REQ-036 TICK_DIV=1, msg_sel=1:
- Load emits C,A,F,E,blank, then ROTATE.
- With TICKER_AUTOSTOP_EN and ROTATIONS=2: after 10 rotate strobes, state=IDLE and done is high for one cycle.
- The ticker content equals its content at ROTATE entry.
REQ-037 TICK_DIV=4: shift_en pulses every 4th cycle, with the first on the 4th edge after start.
- pause held 6 cycles mid-LOAD delays every subsequent strobe by exactly 6 cycles; idx is unchanged.
REQ-038 Mid-ROTATE, start=1 and stop=1 asserted in the same cycle: next state=IDLE, busy=0, no done.
- A start one cycle later is accepted.
REQ-039 reset pulsed during LOAD with idx=2: immediately state=0, shift_en=0, char=7F.
- After release, start reloads from idx 0.
REQ-040 Without TICKER_AUTOSTOP_EN: after 100 rotate strobes, state remains ROTATE and done never asserts.
